// File: rtl/duty_pkg.sv
// duty_pkg: shared widths and playback FSM states for the duty-cycle recorder
package duty_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DUTY_W_DEF = 6;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
endpackage

// File: rtl/duty_playback_engine_pwm_channel.sv
// pwm_channel: glitch-free PWM compare with a shadow duty loaded at counter wrap
module pwm_channel
  import duty_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              load,
  input  logic [DUTY_W-1:0] dc,
  input  logic [DUTY_W-1:0] cnt,
  output logic              pwm
);
  logic [DUTY_W-1:0] shadow;
  // take a new duty only at period boundaries so a pulse is never cut or stretched
  always_ff @(posedge sysclk) begin
    if (reset) shadow <= '0;
    else if (load) shadow <= dc;
  end
  assign pwm = cnt < shadow;
endmodule

// File: rtl/duty_playback_engine.sv
// duty_playback_engine: replays recorded X/Y duty samples at a fixed rate onto two PWM pins
module duty_playback_engine
  import duty_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DUTY_W       = DUTY_W_DEF,
  parameter int TICK_DIV     = 50000,
  parameter int PWM_PRESCALE = 16,
  parameter bit LOOP         = 1'b1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              play_en,
  input  logic [ADDR_W-1:0] rec_len,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DUTY_W-1:0] ram_rd_x,
  input  logic [DUTY_W-1:0] ram_rd_y,
  output logic [DUTY_W-1:0] dc_x,
  output logic [DUTY_W-1:0] dc_y,
  output logic              sample_valid,
  output logic              playing,
  output logic              done,
  output logic              pwm_x,
  output logic              pwm_y
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = PWM_PRESCALE > 1 ? $clog2(PWM_PRESCALE) : 1;
  state_t            state;
  logic [ADDR_W-1:0] addr, len;
  logic [TW-1:0]     tcnt;
  logic [PW-1:0]     pre;
  logic [DUTY_W-1:0] pcnt;
  logic              tick, adv, wrap;
  assign tick        = tcnt == TW'(TICK_DIV - 1);
  assign adv         = pre == PW'(PWM_PRESCALE - 1);
  assign wrap        = adv && pcnt == '1;
  assign playing     = state != IDLE;
  assign ram_rd_en   = state == FETCH;
  assign ram_rd_addr = addr;
  // playback sequencer: fetch, capture, hold until the next sample tick
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      len          <= '0;
      dc_x         <= '0;
      dc_y         <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      if (state != IDLE && !play_en) begin
        state <= IDLE;
        addr  <= '0;
        dc_x  <= '0;
        dc_y  <= '0;
      end else begin
        case (state)
          IDLE: if (play_en && rec_len != '0) begin
            state <= FETCH;
            len   <= rec_len;
            addr  <= '0;
          end
          FETCH: state <= WAIT;
          WAIT: begin
            dc_x         <= ram_rd_x;
            dc_y         <= ram_rd_y;
            sample_valid <= 1'b1;
            state        <= HOLD;
          end
          HOLD: if (tick) begin
            if (addr == len - 1'b1) begin
              addr  <= '0;
              state <= LOOP ? FETCH : IDLE;
              done  <= !LOOP;
            end else begin
              addr  <= addr + 1'b1;
              state <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  // sample-rate divider, held at zero while idle so each start is phase-aligned
  always_ff @(posedge sysclk) begin
    if (reset || state == IDLE) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  end
  // free-running prescaler and PWM period counter shared by both channels
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pre  <= '0;
      pcnt <= '0;
    end else begin
      pre <= adv ? '0 : pre + 1'b1;
      if (adv) pcnt <= pcnt + 1'b1;
    end
  end
  pwm_channel #(.DUTY_W(DUTY_W)) u_pwm_x (
    .sysclk(sysclk), .reset(reset), .load(wrap), .dc(dc_x), .cnt(pcnt), .pwm(pwm_x)
  );
  pwm_channel #(.DUTY_W(DUTY_W)) u_pwm_y (
    .sysclk(sysclk), .reset(reset), .load(wrap), .dc(dc_y), .cnt(pcnt), .pwm(pwm_y)
  );
endmodule

// File: tb/tb_duty_playback_engine.sv
// tb_duty_playback_engine: one-pass and looping engines driven together against a phase-based model
module tb_duty_playback_engine;
  localparam int T = 4;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       play_en = 1'b0;
  logic [7:0] rec_len = '0;
  logic       rd_en[2];
  logic [7:0] rd_addr[2];
  logic [5:0] dcx[2], dcy[2];
  logic       sv[2], ply[2], dn[2], px[2], py[2];
  logic [5:0] mem_x[256], mem_y[256];
  bit         chk = 1'b0;
  int         tests = 0, fails = 0;
  bit         m_act[2], m_done[2];
  int         m_c[2], m_len[2], m_dcx[2], m_dcy[2], m_px[2], m_py[2], m_shx[2], m_shy[2];
  int         m_pcnt = 0;

  initial forever #5 sysclk = ~sysclk;

  initial for (int n = 0; n < 256; n++) begin
    mem_x[n] = 6'(n + 1);
    mem_y[n] = 6'(60 - n);
  end

  // instance 0 plays one pass, instance 1 loops; each has its own 1-cycle-latency RAM
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [5:0] rx, ry;
    always @(posedge sysclk) if (rd_en[g]) begin
      rx <= mem_x[rd_addr[g]];
      ry <= mem_y[rd_addr[g]];
    end
    duty_playback_engine #(
      .ADDR_W(8), .DUTY_W(6), .TICK_DIV(T), .PWM_PRESCALE(1), .LOOP(g == 1)
    ) dut (
      .sysclk(sysclk), .reset(reset), .play_en(play_en), .rec_len(rec_len),
      .ram_rd_en(rd_en[g]), .ram_rd_addr(rd_addr[g]), .ram_rd_x(rx), .ram_rd_y(ry),
      .dc_x(dcx[g]), .dc_y(dcy[g]), .sample_valid(sv[g]), .playing(ply[g]), .done(dn[g]),
      .pwm_x(px[g]), .pwm_y(py[g])
    );
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model: m_c counts cycles since the first fetch; sample k is fetched at phase k*T
  always @(posedge sysclk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 0; m_done[i] = 0; m_c[i] = 0; m_len[i] = 0;
        m_dcx[i] = 0; m_dcy[i] = 0; m_px[i] = 0; m_py[i] = 0; m_shx[i] = 0; m_shy[i] = 0;
      end else begin
        if (m_act[i] && m_c[i] % T == 0) begin
          m_px[i] = mem_x[(m_c[i] / T) % m_len[i]];
          m_py[i] = mem_y[(m_c[i] / T) % m_len[i]];
        end
        if (m_pcnt == 63) begin
          m_shx[i] = m_dcx[i];
          m_shy[i] = m_dcy[i];
        end
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (play_en && rec_len != 0) begin
            m_act[i] = 1; m_c[i] = 0; m_len[i] = rec_len;
          end
        end else if (!play_en) begin
          m_act[i] = 0; m_dcx[i] = 0; m_dcy[i] = 0;
        end else if (i == 0 && m_c[i] == m_len[i] * T - 1) begin
          m_act[i] = 0; m_done[i] = 1;
        end else begin
          m_c[i]++;
          if (m_c[i] % T == 2) begin
            m_dcx[i] = m_px[i];
            m_dcy[i] = m_py[i];
          end
        end
      end
    end
    m_pcnt = reset ? 0 : (m_pcnt + 1) % 64;
  end

  // compare every output of both engines against the model away from the clock edge
  always @(negedge sysclk) if (chk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("playing[%0d]", i), int'(ply[i]), int'(m_act[i]));
      check($sformatf("rd_en[%0d]", i), int'(rd_en[i]), int'(m_act[i] && m_c[i] % T == 0));
      if (m_act[i] && m_c[i] % T == 0)
        check($sformatf("rd_addr[%0d]", i), int'(rd_addr[i]), (m_c[i] / T) % m_len[i]);
      check($sformatf("sample_valid[%0d]", i), int'(sv[i]), int'(m_act[i] && m_c[i] % T == 2));
      check($sformatf("done[%0d]", i), int'(dn[i]), int'(m_done[i]));
      check($sformatf("dc_x[%0d]", i), int'(dcx[i]), m_dcx[i]);
      check($sformatf("dc_y[%0d]", i), int'(dcy[i]), m_dcy[i]);
      check($sformatf("pwm_x[%0d]", i), int'(px[i]), int'(m_pcnt < m_shx[i]));
      check($sformatf("pwm_y[%0d]", i), int'(py[i]), int'(m_pcnt < m_shy[i]));
    end
  end

  initial begin
    @(posedge sysclk);
    #1 chk = 1'b1;
  end

  // directed scenarios with hand-computed expectations, then randomized play
  initial begin
    int na, nsv, last, ndone, nrd, cnt;
    int dseq[$], aseq[$], gaps[$];
    int exp_dc[5] = '{1, 2, 3, 1, 2};
    int exp_ad[5] = '{0, 1, 2, 0, 1};
    int widths[4] = '{10, 40, 0, 63};
    int nxt[4] = '{40, 0, 63, 1};
    bit found;
    repeat (3) @(negedge sysclk);
    for (int i = 0; i < 2; i++) begin
      check("rst_outputs", int'({rd_en[i], sv[i], ply[i], dn[i], px[i], py[i]}), 0);
      check("rst_dc", int'({dcx[i], dcy[i]}), 0);
      check("rst_addr", int'(rd_addr[i]), 0);
    end
    reset = 1'b0;
    nrd = 0;
    repeat (5) begin
      @(negedge sysclk);
      nrd += int'(rd_en[0]) + int'(rd_en[1]);
    end
    check("idle_no_reads", nrd, 0);

    rec_len = 3;
    play_en = 1'b1;
    na = 0; nsv = 0; last = 0;
    for (int k = 0; k < 100 && nsv < 5; k++) begin
      @(negedge sysclk);
      if (rd_en[1] && na < 5) begin aseq.push_back(int'(rd_addr[1])); na++; end
      if (sv[1]) begin
        dseq.push_back(int'(dcx[1]));
        if (nsv > 0) gaps.push_back(k - last);
        last = k;
        nsv++;
      end
    end
    check("loop_samples_seen", nsv, 5);
    for (int k = 0; k < dseq.size(); k++) check($sformatf("loop_dc_x_%0d", k), dseq[k], exp_dc[k]);
    for (int k = 0; k < aseq.size(); k++) check($sformatf("loop_addr_%0d", k), aseq[k], exp_ad[k]);
    foreach (gaps[k]) check($sformatf("loop_gap_%0d", k), gaps[k], 4);
    play_en = 1'b0;
    repeat (3) @(negedge sysclk);

    dseq.delete();
    rec_len = 2;
    play_en = 1'b1;
    found = 0; ndone = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge sysclk);
      if (sv[0]) dseq.push_back(int'(dcx[0]));
      if (dn[0]) begin
        found = 1;
        ndone++;
        check("once_playing_at_done", int'(ply[0]), 0);
        play_en = 1'b0;
      end
    end
    check("once_done_seen", int'(found), 1);
    check("once_sample_count", dseq.size(), 2);
    for (int k = 0; k < dseq.size() && k < 2; k++) check($sformatf("once_dc_x_%0d", k), dseq[k], k + 1);
    nrd = 0;
    repeat (10) begin
      @(negedge sysclk);
      nrd += int'(rd_en[0]);
      ndone += int'(dn[0]);
    end
    check("once_no_reads_after", nrd, 0);
    check("once_done_pulses", ndone, 1);

    rec_len = 0;
    play_en = 1'b1;
    nrd = 0; cnt = 0;
    repeat (10) begin
      @(negedge sysclk);
      nrd += int'(rd_en[0]) + int'(rd_en[1]);
      cnt += int'(ply[0]) + int'(ply[1]);
    end
    check("empty_no_reads", nrd, 0);
    check("empty_not_playing", cnt, 0);
    play_en = 1'b0;
    @(negedge sysclk);

    rec_len = 3;
    play_en = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge sysclk);
      found = rd_en[1] && rd_addr[1] == 8'd1;
    end
    check("abort_second_fetch", int'(found), 1);
    @(negedge sysclk);
    check("abort_dc_before", int'(dcx[1]), 1);
    play_en = 1'b0;
    @(negedge sysclk);
    check("abort_dc_x", int'(dcx[1]), 0);
    check("abort_playing", int'(ply[1]), 0);
    play_en = 1'b1;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge sysclk);
      found = rd_en[1];
    end
    check("restart_fetch", int'(found), 1);
    check("restart_addr", int'(rd_addr[1]), 0);
    play_en = 1'b0;
    @(negedge sysclk);

    mem_x[0] = 10;
    rec_len = 1;
    play_en = 1'b1;
    repeat (70) @(negedge sysclk);
    found = 0;
    for (int k = 0; k < 70 && !found; k++) begin
      if (m_pcnt == 0) found = 1;
      else @(negedge sysclk);
    end
    check("pwm_align", int'(found), 1);
    for (int p = 0; p < 4; p++) begin
      cnt = 0;
      for (int k = 0; k < 64; k++) begin
        cnt += int'(px[1]);
        if (k == 30) mem_x[0] = 6'(nxt[p]);
        @(negedge sysclk);
      end
      check($sformatf("pwm_width_%0d", p), cnt, widths[p]);
    end
    play_en = 1'b0;
    repeat (3) @(negedge sysclk);

    for (int k = 0; k < 800; k++) begin
      @(negedge sysclk);
      reset = 1'b0;
      if ($urandom_range(0, 19) == 0) play_en = ~play_en;
      if ($urandom_range(0, 29) == 0) rec_len = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) begin
        mem_x[$urandom_range(0, 5)] = 6'($urandom);
        mem_y[$urandom_range(0, 5)] = 6'($urandom);
      end
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    @(negedge sysclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
